// File: rtl/print_arbiter.sv
// Two-port round-robin byte arbiter in front of a printer UART transmitter.
// Sends a wake byte after a power-up delay. Optional printer flow control is enabled with `define PRN_FLOW_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAKEDLY  | counting the post-reset delay before the wake byte
// WAKE     | wake byte presented to the transmitter until tx_done
// IDLE     | arbitrating between the command and keyboard requesters
// SEND     | granted byte presented to the transmitter until tx_done
// GAP      | enforced idle spacing after every transmitted byte
module print_arbiter #(
   parameter int unsigned WAKE_DELAY = 50000000,
   parameter logic [7:0]  WAKE_BYTE  = 8'hFF,
   parameter int unsigned GAP_CYCLES = 2604
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_byte,
   output logic       cmd_ready,
   input  logic       key_valid,
   input  logic [7:0] key_byte,
   output logic       key_ready,
   output logic       tx_set_byte,
   output logic [7:0] tx_byte,
   input  logic       tx_done,
   input  logic       prn_busy,
   output logic       grant_cmd,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_WAKEDLY,
      ST_WAKE,
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   // Terminal counts; a zero parameter degenerates to a single cycle.
   localparam logic [31:0] WAKE_LAST = (WAKE_DELAY > 0) ? 32'(WAKE_DELAY - 1) : 32'd0;
   localparam logic [31:0] GAP_LAST  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  hold_q, hold_d;
   logic        last_cmd_q, last_cmd_d;

   logic        grant_ok;
   logic        pick_cmd;
   logic        pick_key;

`ifdef PRN_FLOW_EN
   assign grant_ok = ~prn_busy;
`else
   logic prn_busy_unused;
   assign prn_busy_unused = prn_busy;
   assign grant_ok        = 1'b1;
`endif

   // On a tie the port that did not win last time is served.
   assign pick_cmd = cmd_valid & (~key_valid | ~last_cmd_q);
   assign pick_key = key_valid & (~cmd_valid |  last_cmd_q);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= ST_WAKEDLY;
         cnt_q      <= '0;
         hold_q     <= '0;
         last_cmd_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         last_cmd_q <= last_cmd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      hold_d      = hold_q;
      last_cmd_d  = last_cmd_q;
      cmd_ready   = 1'b0;
      key_ready   = 1'b0;
      tx_set_byte = 1'b0;
      tx_byte     = 8'h00;
      case (state_q)
         ST_WAKEDLY: begin
            if (cnt_q == WAKE_LAST) begin
               state_d = ST_WAKE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_WAKE: begin
            tx_set_byte = 1'b1;
            tx_byte     = WAKE_BYTE;
            if (tx_done) begin
               state_d = ST_GAP;
            end
         end
         ST_IDLE: begin
            if (grant_ok && pick_cmd) begin
               cmd_ready  = 1'b1;
               hold_d     = cmd_byte;
               last_cmd_d = 1'b1;
               state_d    = ST_SEND;
            end else if (grant_ok && pick_key) begin
               key_ready  = 1'b1;
               hold_d     = key_byte;
               last_cmd_d = 1'b0;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            tx_set_byte = 1'b1;
            tx_byte     = hold_q;
            if (tx_done) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            // cnt_q is zero on entry because WAKE/SEND leave it at its default.
            if (cnt_q >= GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_WAKEDLY;
         end
      endcase
   end

   assign grant_cmd = last_cmd_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/print_arbiter.md
PRINT_ARBITER -- requirements
Module: print_arbiter

Interface
REQ-001 Parameter WAKE_DELAY, default 50000000, cycles waited after reset before the wake byte is sent.
REQ-002 Parameter WAKE_BYTE, default 8'hFF, printer wake byte.
REQ-003 Parameter GAP_CYCLES, default 2604, idle cycles inserted after every transmitted byte.
REQ-004 clk  input  1  single clock (CLOCK_50 domain).
REQ-005 rst_l  input  1  reset; asynchronous, active-low.
REQ-006 cmd_valid  input  1  command requester has a byte.
REQ-007 cmd_byte  input  8  command byte.
REQ-008 cmd_ready  output  1  command byte accepted this cycle.
REQ-009 key_valid  input  1  keyboard requester has a byte.
REQ-010 key_byte  input  8  keyboard byte.
REQ-011 key_ready  output  1  keyboard byte accepted this cycle.
REQ-012 tx_set_byte  output  1  level request to UART transmitter.
REQ-013 tx_byte  output  8  byte presented to transmitter.
REQ-014 tx_done  input  1  one-cycle pulse from transmitter at end of stop bit.
REQ-015 prn_busy  input  1  printer flow-control busy (used only per REQ-030).
REQ-016 grant_cmd  output  1  1 = last grant went to command port, 0 = keyboard.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: WAKEDLY, WAKE, IDLE, SEND, GAP.
REQ-019 WAKEDLY: 32-bit counter increments each cycle; when count == WAKE_DELAY-1, go to WAKE next cycle.
REQ-020 WAKE: tx_set_byte=1, tx_byte=WAKE_BYTE; on tx_done go to GAP.
REQ-021 IDLE: if exactly one valid, grant it; if both valid, grant the port not in last_grant (round-robin); if none valid, stay.
REQ-022 Grant: winner's ready high for exactly one cycle in IDLE, byte latched into hold register that cycle, last_grant/grant_cmd updated, go to SEND.
REQ-023 Loser's ready stays 0; its valid/byte must be held by requester until accepted.
REQ-024 SEND: tx_set_byte=1, tx_byte=hold register, from cycle after accept (latency 1) until tx_done; on tx_done go to GAP, tx_set_byte 0 the following cycle.
REQ-025 GAP: gap counter cleared on entry, increments; after GAP_CYCLES cycles in GAP, go to IDLE; GAP_CYCLES=0 means one cycle in GAP.
REQ-026 tx_done outside WAKE/SEND is ignored; tx_byte = 8'h00 outside WAKE/SEND.
REQ-027 Readies never asserted outside IDLE; valid changes outside IDLE have no effect.

Reset
REQ-028 rst_l low: state WAKEDLY, counters 0, hold 0, tx_set_byte 0, tx_byte 0, cmd_ready 0, key_ready 0, busy 1, grant_cmd 0 (last_grant = keyboard, so first tie goes to command).
REQ-029 Reset mid-SEND aborts the request immediately; after release the full wake delay and wake byte repeat.

Configuration
REQ-030 Macro PRN_FLOW_EN defined: IDLE grants nothing while prn_busy=1; pending requests granted in first cycle prn_busy=0. Undefined: prn_busy ignored, port retained.

Verification (WAKE_DELAY=10, GAP_CYCLES=4)
REQ-031 Release reset, no valids -> tx_set_byte rises 10 cycles after reset release with tx_byte=8'hFF; busy stays 1 until IDLE.
REQ-032 After wake, key_valid=1 key_byte=8'h41 -> key_ready one cycle, next cycle tx_set_byte=1 tx_byte=8'h41 until tx_done; IDLE 5 cycles after tx_done.
REQ-033 Both valid continuously (cmd 8'h1B, key 8'h61) -> transmit order 8'h1B, 8'h61, 8'h1B, 8'h61.
REQ-034 key_valid asserted during GAP -> no key_ready until IDLE; tx_done pulse injected in GAP -> no state change.
REQ-035 Reset pulse mid-SEND -> tx_set_byte 0 immediately; after release, 8'hFF re-sent before any request byte.
REQ-036 PRN_FLOW_EN defined, prn_busy=1, cmd_valid=1 -> no cmd_ready; prn_busy drops -> cmd_ready same cycle.
